// File: rtl/mux_81_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mux_81_sel_sequencer
// Purpose  : Parallel-to-serial front end for an 8:1 mux. A word accepted on
//            the load handshake is held on the mux data inputs (i). The mux
//            select (s) then steps through all eight positions, advancing one
//            position per bit consumed downstream. The mux output becomes the
//            serial bit stream, qualified by bit_valid and last.
// Ports    : clk         - clock, all state changes on rising edge
//            rst_n       - synchronous active-low reset
//            load_valid  - upstream word available
//            load_data   - upstream parallel word
//            load_ready  - block can accept a word this cycle
//            i           - held word, drives mux data input
//            s           - select, drives mux select
//            bit_valid   - current s/i pair selects a valid serial bit
//            bit_ready   - downstream consumed the current bit
//            last        - current bit is the final bit of the word
//            flush       - synchronous abort of the current frame
//            frame_cnt   - count of fully serialized words (wraps)
// Options  : MUX_81_SEL_PREFETCH_EN - adds a one-word prefetch register so
//            frames can run back-to-back with no idle cycle between them.
// Revision : 1.0 - initial release
// ============================================================================
module mux_81_sel_sequencer #(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = 3,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic [WIDTH-1:0] i,
    output logic [SEL_W-1:0] s,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             last,
    input  logic             flush,
    output logic [7:0]       frame_cnt
);

    localparam logic [SEL_W-1:0] c_START = (MSB_FIRST != 0) ? SEL_W'(WIDTH - 1) : '0;
    localparam logic [SEL_W-1:0] c_END   = (MSB_FIRST != 0) ? '0 : SEL_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_i, w_i_nxt;
    logic [SEL_W-1:0] r_s, w_s_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic             w_load_ready;
    logic             w_accept;
    logic             w_at_end;
    logic [SEL_W-1:0] w_s_step;

`ifdef MUX_81_SEL_PREFETCH_EN
    logic             r_pf_full, w_pf_full_nxt;
    logic [WIDTH-1:0] r_pf_data, w_pf_data_nxt;

    // While shifting, a word may be taken whenever the prefetch slot is free.
    assign w_load_ready = !flush && ((r_state == IDLE) || !r_pf_full);
`else
    assign w_load_ready = !flush && (r_state == IDLE);
`endif

    assign w_accept = load_valid && w_load_ready;
    assign w_at_end = (r_s == c_END);
    assign w_s_step = (MSB_FIRST != 0) ? (r_s - 1'b1) : (r_s + 1'b1);

    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_s_nxt     = r_s;
        w_cnt_nxt   = r_cnt;
`ifdef MUX_81_SEL_PREFETCH_EN
        w_pf_full_nxt = r_pf_full;
        w_pf_data_nxt = r_pf_data;
`endif
        if (flush) begin
            // Abort wins over everything; the held word is left in place.
            w_state_nxt = IDLE;
            w_s_nxt     = c_START;
`ifdef MUX_81_SEL_PREFETCH_EN
            w_pf_full_nxt = 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_i_nxt     = load_data;
                        w_s_nxt     = c_START;
                        w_state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
`ifdef MUX_81_SEL_PREFETCH_EN
                    if (w_accept) begin
                        w_pf_full_nxt = 1'b1;
                        w_pf_data_nxt = load_data;
                    end
`endif
                    if (bit_ready) begin
                        if (!w_at_end) begin
                            w_s_nxt = w_s_step;
                        end else begin
                            w_cnt_nxt = r_cnt + 8'd1;
                            w_s_nxt   = c_START;
`ifdef MUX_81_SEL_PREFETCH_EN
                            if (r_pf_full) begin
                                w_i_nxt       = r_pf_data;
                                w_pf_full_nxt = 1'b0;
                            end else if (w_accept) begin
                                // Word arriving on the final bit bypasses the slot.
                                w_i_nxt       = load_data;
                                w_pf_full_nxt = 1'b0;
                            end else begin
                                w_state_nxt = IDLE;
                            end
`else
                            w_state_nxt = IDLE;
`endif
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_s_nxt     = c_START;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_i     <= '0;
            r_s     <= c_START;
            r_cnt   <= 8'd0;
`ifdef MUX_81_SEL_PREFETCH_EN
            r_pf_full <= 1'b0;
            r_pf_data <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_s     <= w_s_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef MUX_81_SEL_PREFETCH_EN
            r_pf_full <= w_pf_full_nxt;
            r_pf_data <= w_pf_data_nxt;
`endif
        end
    end

    assign load_ready = w_load_ready;
    assign i          = r_i;
    assign s          = r_s;
    assign bit_valid  = (r_state == SHIFT);
    assign last       = bit_valid && w_at_end;
    assign frame_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mux_81_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_81_sel_sequencer
// Purpose  : Self-checking bench. Two sequencers (LSB-first and MSB-first)
//            share one stimulus. A frame-level reference model tracks the
//            held word, the number of bits consumed and the queue of waiting
//            words, and every cycle's outputs are compared against it. The
//            scenario tasks add their own directed checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_81_sel_sequencer;

`ifdef MUX_81_SEL_PREFETCH_EN
    localparam bit PF_EN = 1'b1;
`else
    localparam bit PF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, load_valid, bit_ready, flush;
    logic [7:0] load_data;

    logic       lr0, bv0, last0, lr1, bv1, last1;
    logic [7:0] i0, i1, cnt0, cnt1;
    logic [2:0] s0, s1;
    logic       y0, y1;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mux_81_sel_sequencer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
        .load_ready(lr0), .i(i0), .s(s0), .bit_valid(bv0), .bit_ready(bit_ready),
        .last(last0), .flush(flush), .frame_cnt(cnt0)
    );

    mux_81_sel_sequencer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
        .load_ready(lr1), .i(i1), .s(s1), .bit_valid(bv1), .bit_ready(bit_ready),
        .last(last1), .flush(flush), .frame_cnt(cnt1)
    );

    // The 8:1 mux each sequencer drives.
    assign y0 = i0[s0];
    assign y1 = i1[s1];

    // ---------------- frame-level reference model ----------------
    bit         m_busy = 1'b0;
    bit         m_acc  = 1'b0;
    int         m_k    = 0;       // bits already consumed in the current word
    logic [7:0] m_word = 8'h00;
    logic [7:0] m_cnt  = 8'h00;
    logic [7:0] m_pfq[$];         // words accepted but not yet started

    always @(posedge clk) begin
        m_acc = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0; m_k = 0; m_word = 8'h00; m_cnt = 8'h00;
            m_pfq.delete();
        end else if (flush) begin
            m_busy = 1'b0; m_k = 0;
            m_pfq.delete();
        end else if (!m_busy) begin
            if (load_valid) begin
                m_acc = 1'b1; m_word = load_data; m_k = 0; m_busy = 1'b1;
            end
        end else begin
            if (load_valid && PF_EN && m_pfq.size() == 0) begin
                m_pfq.push_back(load_data);
                m_acc = 1'b1;
            end
            if (bit_ready) begin
                if (m_k < 7) begin
                    m_k = m_k + 1;
                end else begin
                    m_cnt = m_cnt + 8'd1;
                    m_k   = 0;
                    if (m_pfq.size() > 0) m_word = m_pfq.pop_front();
                    else                  m_busy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic       exp_lr, exp_last;
            logic [2:0] exp_s0, exp_s1;
            exp_lr   = !flush && (!m_busy || (PF_EN && m_pfq.size() == 0));
            exp_s0   = 3'(m_k);
            exp_s1   = 3'(7 - m_k);
            exp_last = m_busy && (m_k == 7);
            n_chk++;
            if ({lr0, i0, s0, bv0, last0, cnt0} !== {exp_lr, m_word, exp_s0, m_busy, exp_last, m_cnt}) begin
                n_fail++;
                $display("FAIL model_lsb t=%0t got lr=%b i=%h s=%0d bv=%b last=%b cnt=%0d expected lr=%b i=%h s=%0d bv=%b last=%b cnt=%0d",
                         $time, lr0, i0, s0, bv0, last0, cnt0, exp_lr, m_word, exp_s0, m_busy, exp_last, m_cnt);
            end
            n_chk++;
            if ({lr1, i1, s1, bv1, last1, cnt1} !== {exp_lr, m_word, exp_s1, m_busy, exp_last, m_cnt}) begin
                n_fail++;
                $display("FAIL model_msb t=%0t got lr=%b i=%h s=%0d bv=%b last=%b cnt=%0d expected lr=%b i=%h s=%0d bv=%b last=%b cnt=%0d",
                         $time, lr1, i1, s1, bv1, last1, cnt1, exp_lr, m_word, exp_s1, m_busy, exp_last, m_cnt);
            end
            if (m_busy) begin
                n_chk++;
                if ({y0, y1} !== {m_word[m_k], m_word[7 - m_k]}) begin
                    n_fail++;
                    $display("FAIL model_y t=%0t got y_lsb=%b y_msb=%b expected %b %b",
                             $time, y0, y1, m_word[m_k], m_word[7 - m_k]);
                end
            end
        end
    end

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        rst_n = 1'b0; load_valid = 1'b0; load_data = 8'h00; bit_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({i0, s0, s1, bv0, last0, cnt0, lr0} !== {8'h00, 3'd0, 3'd7, 1'b0, 1'b0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values got i=%h s=%0d/%0d bv=%b last=%b cnt=%0d lr=%b expected 00 0/7 0 0 0 1",
                     i0, s0, s1, bv0, last0, cnt0, lr0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic load_word(input logic [7:0] w);
        @(posedge clk); #1 load_valid = 1'b1; load_data = w;
        @(posedge clk); #1 load_valid = 1'b0;
    endtask

    task automatic test_lsb_frame();
        int exp_y[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        bit_ready = 1'b1;
        load_word(8'hA5);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            n_chk++;
            if ({s0, y0, last0} !== {3'(b), 1'(exp_y[b]), (b == 7)}) begin
                n_fail++;
                $display("FAIL lsb_bit%0d got s=%0d y=%b last=%b expected s=%0d y=%0d last=%b",
                         b, s0, y0, last0, b, exp_y[b], (b == 7));
            end
        end
        @(negedge clk);
        n_chk++;
        if ({bv0, cnt0} !== {1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL lsb_done got bv=%b cnt=%0d expected bv=0 cnt=1", bv0, cnt0);
        end
    endtask

    task automatic test_msb_frame();
        bit_ready = 1'b1;
        load_word(8'h01);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            n_chk++;
            if ({s1, y1, last1} !== {3'(7 - b), (b == 7), (b == 7)}) begin
                n_fail++;
                $display("FAIL msb_bit%0d got s=%0d y=%b last=%b expected s=%0d y=%b last=%b",
                         b, s1, y1, last1, 7 - b, (b == 7), (b == 7));
            end
        end
        @(negedge clk);
        n_chk++;
        if ({bv1, cnt1} !== {1'b0, 8'd2}) begin
            n_fail++;
            $display("FAIL msb_done got bv=%b cnt=%0d expected bv=0 cnt=2", bv1, cnt1);
        end
    endtask

    task automatic test_bit_ready_stall();
        int taken = 0;
        int cyc   = 0;
        bit_ready = 1'b1;
        load_word(8'h3C);
        while (taken < 8 && cyc < 60) begin
            @(negedge clk);
            n_chk++;
            if ({bv0, i0, s0} !== {1'b1, 8'h3C, 3'(taken)}) begin
                n_fail++;
                $display("FAIL stall_cyc%0d got bv=%b i=%h s=%0d expected bv=1 i=3c s=%0d",
                         cyc, bv0, i0, s0, taken);
            end
            @(posedge clk);
            if (bit_ready) taken++;
            cyc++;
            #1 bit_ready = ((cyc % 3) == 0);
        end
        n_chk++;
        if (taken != 8) begin
            n_fail++;
            $display("FAIL stall_timeout got %0d bits expected 8", taken);
        end
        bit_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({bv0, cnt0} !== {1'b0, 8'd3}) begin
            n_fail++;
            $display("FAIL stall_done got bv=%b cnt=%0d expected bv=0 cnt=3", bv0, cnt0);
        end
    endtask

    task automatic test_flush();
        logic [7:0] cnt_before;
        bit_ready = 1'b1;
        load_word(8'h5A);
        repeat (4) @(posedge clk);
        #1 flush = 1'b1;
        cnt_before = m_cnt;
        @(negedge clk);
        n_chk++;
        if ({s0, lr0} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_pre got s=%0d lr=%b expected s=4 lr=0", s0, lr0);
        end
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bv0, s0, s1, cnt0} !== {1'b0, 3'd0, 3'd7, cnt_before}) begin
            n_fail++;
            $display("FAIL flush_post got bv=%b s=%0d/%0d cnt=%0d expected bv=0 s=0/7 cnt=%0d",
                     bv0, s0, s1, cnt0, cnt_before);
        end
        load_word(8'hFF);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            n_chk++;
            if ({bv0, s0, y0} !== {1'b1, 3'(b), 1'b1}) begin
                n_fail++;
                $display("FAIL flush_reload_bit%0d got bv=%b s=%0d y=%b expected 1 %0d 1", b, bv0, s0, y0, b);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        bit_ready = 1'b1;
        load_word(8'hC3);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        n_chk++;
        if (s0 !== 3'd5) begin
            n_fail++;
            $display("FAIL rst_mid_pre got s=%0d expected 5", s0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({i0, s0, s1, bv0, last0, cnt0, lr0} !== {8'h00, 3'd0, 3'd7, 1'b0, 1'b0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_mid_post got i=%h s=%0d/%0d bv=%b last=%b cnt=%0d lr=%b expected 00 0/7 0 0 0 1",
                     i0, s0, s1, bv0, last0, cnt0, lr0);
        end
    endtask

    task automatic test_back_to_back();
        int w = 0, gaps = 0, lasts = 0, cyc = 0;
        bit started = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        bit_ready = 1'b1; load_valid = 1'b1; load_data = 8'h00;
        while (lasts < 256 && cyc < 5000) begin
            @(negedge clk);
            if (bv0) started = 1'b1;
            else if (started) gaps++;
            if (bv0 && last0) lasts++;
            @(posedge clk);
            #1;
            if (m_acc) begin
                w++;
                if (w == 256) load_valid = 1'b0;
                else          load_data  = 8'(w);
            end
            cyc++;
        end
        load_valid = 1'b0;
        n_chk++;
        if (lasts != 256 || w != 256) begin
            n_fail++;
            $display("FAIL stream_count got frames=%0d words=%0d expected 256 256", lasts, w);
        end
        n_chk++;
        if (gaps != (PF_EN ? 0 : 255)) begin
            n_fail++;
            $display("FAIL stream_gaps got %0d expected %0d", gaps, PF_EN ? 0 : 255);
        end
        @(negedge clk);
        n_chk++;
        if ({bv0, cnt0, cnt1} !== {1'b0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL stream_wrap got bv=%b cnt=%0d/%0d expected bv=0 cnt=0/0", bv0, cnt0, cnt1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            rst_n      = ($urandom_range(99) != 0);
            flush      = ($urandom_range(19) == 0);
            load_valid = $urandom_range(1) == 1;
            load_data  = 8'($urandom);
            bit_ready  = ($urandom_range(3) != 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1; flush = 1'b0; load_valid = 1'b0; bit_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (bv0 !== 1'b0) begin
            n_fail++;
            $display("FAIL random_drain got bv=%b expected 0", bv0);
        end
    endtask

    initial begin
        test_reset();
        test_lsb_frame();
        test_msb_frame();
        test_bit_ready_stall();
        test_flush();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_81_sel_sequencer.md
Name: mux_81_sel_sequencer

Overview:
Parallel-to-serial front end for the 8:1 data-flow mux (mux_81).
- Accepts a parallel word over a valid/ready handshake.
- Holds the word stable on the mux data inputs and steps the mux select through all 8 positions, one per accepted bit.
- The mux output y is then the serial bit stream, qualified by bit_valid/last from this block.

Parameters:
WIDTH, 8, word width; fixed to 8 to match the mux data input.
SEL_W, 3, select width; must equal log2(WIDTH).
MSB_FIRST, 0, 0 = select order 0..7; 1 = select order 7..0.

Ports:
clk  input  1  single clock; all state changes on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
load_valid  input  1  upstream word available.
load_data  input  8  upstream parallel word.
load_ready  output  1  block can accept a word this cycle.
i  output  8  held word, drives mux data input i.
s  output  3  select, drives mux select s.
bit_valid  output  1  current s/i pair selects a valid serial bit.
bit_ready  input  1  downstream has consumed the current bit.
last  output  1  current bit is the final bit of the word.
flush  input  1  synchronous abort of the current frame.
frame_cnt  output  8  count of fully serialized words.

Behaviour:
- Reset (rst_n=0 at edge) sets: state=IDLE, i=0, s=START, bit_valid=0, last=0, frame_cnt=0, prefetch buffer empty.
- Reset overrides all inputs and aborts any frame immediately.
- Index definitions: START=0/END=7 when MSB_FIRST=0; START=7/END=0 when MSB_FIRST=1. Step is +1 or −1 respectively.
- IDLE state:
  - load_ready=1, bit_valid=0.
  - On load_valid: i<=load_data, s<=START, go to SHIFT. bit_valid=1 from the next cycle (1-cycle load latency).
- SHIFT state:
  - bit_valid=1; i is held constant for the whole frame.
  - bit_ready=0: s and i hold.
  - bit_ready=1 and s!=END: s<=s+step.
  - bit_ready=1 and s==END: frame done, frame_cnt<=frame_cnt+1 (wraps 255->0).
    - Next word available (see Optional Feature): load it, s<=START, stay in SHIFT.
    - Otherwise: go to IDLE, bit_valid<=0.
- Output decode: last = bit_valid & (s==END), combinational from registered state.
- load_ready=0 in SHIFT (without the optional feature).
- Each frame is exactly 8 accepted bits; no partial frames except via flush or reset.
- flush=1: go to IDLE next cycle, drop the current frame and any prefetched word, s<=START, frame_cnt unchanged.
- flush has priority over load_valid and bit_ready in the same cycle.
- A load_valid coincident with flush in IDLE is not accepted: load_ready is forced to 0 while flush=1.

Optional Feature:
MUX_81_SEL_PREFETCH_EN
- Defined: adds a one-word prefetch register.
  - In SHIFT, load_ready = !prefetch_full; a handshake there fills the prefetch register.
  - At END with bit_ready=1, the prefetch word moves to i with s<=START, with no idle cycle between frames (back-to-back 8-bit frames).
  - If the prefetch fills in the same cycle as END completes, that word is forwarded directly to i and the prefetch register stays empty.
- Not defined: no prefetch register; load_ready=0 throughout SHIFT; at least one IDLE cycle between frames.

Test Plan:
1. Reset then load 8'hA5 with bit_ready=1 constantly, MSB_FIRST=0:
   - s steps 0..7 over 8 cycles; mux y yields 1,0,1,0,0,1,0,1.
   - last=1 only at s=7; frame_cnt=1; returns to IDLE with bit_valid=0.
2. MSB_FIRST=1, load 8'h01, bit_ready=1:
   - s steps 7..0; y=0 for 7 bits, then 1 with last=1.
3. Load 8'h3C, toggle bit_ready 1,0,0,1,...:
   - s advances only on bit_ready=1; i stays 8'h3C throughout.
   - bit_valid stays 1 until the 8th accepted bit.
4. Assert flush at s=4 mid-frame:
   - Next cycle IDLE, bit_valid=0, s=0, frame_cnt unchanged.
   - The next load of 8'hFF starts cleanly from s=0.
5. Assert rst_n=0 at s=5:
   - Next edge all outputs are at reset values and frame_cnt=0; load_ready=1 once rst_n=1.
6. With MUX_81_SEL_PREFETCH_EN, stream 256 words (8'h00..8'hFF) with bit_ready=1:
   - No bit_valid gaps between frames.
   - frame_cnt wraps to 0 after the last word.
   - Without the macro, exactly one bit_valid=0 cycle separates frames.
